mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_AW, default 6, word-address width of the data RAM (2**RAM_AW 32-bit words).
REQ-002 Parameter FIFO_DEPTH, default 8, number of TX FIFO entries (power of two, minimum 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low (0 = reset), sampled on the rising edge of clk.
REQ-005 memwrite  input  1  processor data-port write strobe.
REQ-006 addr  input  32  processor data-port byte address (the processor's aluout).
REQ-007 writedata  input  32  processor store data.
REQ-008 readdata  output  32  load data returned to the processor, combinational from addr.
REQ-009 tx_data  output  8  byte at the FIFO head.
REQ-010 tx_valid  output  1  FIFO not empty.
REQ-011 tx_ready  input  1  downstream accepts tx_data.
REQ-012 timer_irq  output  1  timer match flag.

Function
REQ-013 The block SHALL ignore addr[1:0]; all accesses are 32-bit words.
REQ-014 The block SHALL decode addr[31]=0 as RAM, indexed by addr[RAM_AW+1:2], with higher index bits ignored (aliasing wrap).
REQ-015 The block SHALL decode addr[31:16]=0xFFFF with addr[15:5]=0 as MMIO: 0x00 TXDATA, 0x04 TXSTAT, 0x08 TCOUNT, 0x0C TCMP, 0x10 TFLAG.
REQ-016 The block SHALL return 0 on reads of any other address and SHALL ignore writes to them.
REQ-017 RAM reads SHALL be combinational (0-cycle latency), and a RAM write with memwrite=1 SHALL take effect at the rising edge.
REQ-018 The block SHALL never return the value being written to an address in the same cycle; the old value SHALL be returned.
REQ-019 All MMIO reads SHALL be combinational from the current register state.
REQ-020 A TXDATA write SHALL push writedata[7:0]; a TXDATA read SHALL return 0.
REQ-021 A push SHALL be accepted if count<FIFO_DEPTH, or if a pop (tx_valid&tx_ready) occurs in the same cycle.
REQ-022 A push that is not accepted SHALL drop the byte and set the sticky overflow bit.
REQ-023 A pop SHALL occur when tx_valid&tx_ready; on simultaneous push and pop, count SHALL be unchanged.
REQ-024 tx_data SHALL hold stable while tx_valid&!tx_ready.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and bytes SHALL leave in FIFO order.
REQ-026 A TXSTAT read SHALL return bit0 full, bit1 empty, bit2 overflow, bits[7:3] count, and all other bits 0.
REQ-027 A TXSTAT write with writedata[2]=1 SHALL clear overflow; if an overflowing push occurs in the same cycle, set SHALL win.
REQ-028 TCOUNT SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0.
REQ-029 A TCOUNT write SHALL load writedata and suppress the increment for that cycle.
REQ-030 TCMP SHALL be a read/write register.
REQ-031 TFLAG bit0 SHALL set at the edge following any cycle where TCMP!=0 and TCOUNT==TCMP.
REQ-032 A TFLAG write with writedata[0]=1 SHALL clear the flag; a simultaneous set SHALL win.
REQ-033 timer_irq SHALL equal TFLAG bit0.

Reset
REQ-034 On reset=0 at a rising edge, the block SHALL clear the FIFO pointers and count, overflow, TCOUNT, TCMP and TFLAG to 0; tx_valid=0 and timer_irq=0 SHALL follow.
REQ-035 RAM contents SHALL NOT be reset.
REQ-036 Reset SHALL take priority over any concurrent write, push or pop, including one mid-transfer.

Verification
REQ-037 RAM: write 0xDEADBEEF to 0x40, then read 0x40 and 0x40+(4<<RAM_AW) -> both return 0xDEADBEEF; a read of 0x41 also returns 0xDEADBEEF.
REQ-038 FIFO: with tx_ready=0, push 0x01..0x09 -> after 8 pushes TXSTAT=0x41 (count 8, full); the 9th push sets overflow; raise tx_ready -> 0x01..0x08 emerge in order, then TXSTAT=0x06.
REQ-039 Full FIFO with simultaneous push 0xAA and pop -> push accepted, count stays 8, overflow stays 0, 0xAA is the last byte out.
REQ-040 Timer: write TCMP=20 and TCOUNT=10 -> timer_irq rises exactly 11 cycles after the TCOUNT write edge; write TFLAG=1 -> irq falls next cycle; writing TCOUNT=0xFFFFFFFE shows a wrap to 0.
REQ-041 Reset: assert reset=0 for one edge with 3 bytes queued and TFLAG set -> tx_valid=0, TXSTAT=0x02, TCOUNT=0 after the edge, and RAM data is retained.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-mapped responder for a small processor data port: word RAM, a byte TX FIFO
// and a free-running timer with compare flag, all readable combinationally.
module mem_responder #(
   parameter int RAM_AW     = 6,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]       ram_q [2**RAM_AW];
   logic [7:0]        fifo_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [31:0]       tcount_q, tcount_d;
   logic [31:0]       tcmp_q, tcmp_d;
   logic              tflag_q, tflag_d;

   logic [RAM_AW-1:0] ram_idx;
   logic [2:0]        reg_idx;
   logic              sel_ram, sel_mmio;
   logic              ram_we, wr_tx, wr_stat, wr_tcount, wr_tcmp, wr_tflag;
   logic              full, empty, push, pop, ovf_set, tflag_set;
   logic [31:0]       txstat;
   logic              unused_addr;

   // Byte-lane bits are irrelevant: every access is a whole word.
   assign unused_addr = ^addr[1:0];

   assign ram_idx  = addr[RAM_AW+1:2];
   assign reg_idx  = addr[4:2];
   assign sel_ram  = ~addr[31];
   assign sel_mmio = (addr[31:16] == 16'hFFFF) && (addr[15:5] == 11'd0);

   assign ram_we    = memwrite & sel_ram;
   assign wr_tx     = memwrite & sel_mmio & (reg_idx == 3'd0);
   assign wr_stat   = memwrite & sel_mmio & (reg_idx == 3'd1);
   assign wr_tcount = memwrite & sel_mmio & (reg_idx == 3'd2);
   assign wr_tcmp   = memwrite & sel_mmio & (reg_idx == 3'd3);
   assign wr_tflag  = memwrite & sel_mmio & (reg_idx == 3'd4);

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign tx_valid  = ~empty;
   assign tx_data   = fifo_q[rd_ptr_q];
   assign pop       = tx_valid & tx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
   assign push      = wr_tx & (~full | pop);
   assign ovf_set   = wr_tx & full & ~pop;
   assign tflag_set = (tcmp_q != 32'd0) && (tcount_q == tcmp_q);
   assign timer_irq = tflag_q;

   assign txstat = {24'd0, 5'(count_q), ovf_q, empty, full};

   always_comb begin
      readdata = 32'd0;
      if (sel_ram) begin
         readdata = ram_q[ram_idx];
      end else if (sel_mmio) begin
         case (reg_idx)
            3'd1:    readdata = txstat;
            3'd2:    readdata = tcount_q;
            3'd3:    readdata = tcmp_q;
            3'd4:    readdata = {31'd0, tflag_q};
            default: readdata = 32'd0;
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      ovf_d = ovf_q;
      if (ovf_set)                    ovf_d = 1'b1;
      else if (wr_stat && writedata[2]) ovf_d = 1'b0;

      tcount_d = wr_tcount ? writedata : tcount_q + 32'd1;
      tcmp_d   = wr_tcmp ? writedata : tcmp_q;

      tflag_d = tflag_q;
      if (tflag_set)                     tflag_d = 1'b1;
      else if (wr_tflag && writedata[0]) tflag_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         tcount_q <= 32'd0;
         tcmp_q   <= 32'd0;
         tflag_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         tcount_q <= tcount_d;
         tcmp_q   <= tcmp_d;
         tflag_q  <= tflag_d;
      end
   end

   // Storage arrays are never cleared, but reset still blocks any write in flight.
   always_ff @(posedge clk) begin
      if (reset && ram_we) ram_q[ram_idx] <= writedata;
   end

   always_ff @(posedge clk) begin
      if (reset && push) fifo_q[wr_ptr_q] <= writedata[7:0];
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and random checks of mem_responder against a queue/array reference model.
module tb_mem_responder;

   localparam int AW    = 6;
   localparam int DEPTH = 8;
   localparam logic [31:0] A_TXDATA = 32'hFFFF0000;
   localparam logic [31:0] A_TXSTAT = 32'hFFFF0004;
   localparam logic [31:0] A_TCOUNT = 32'hFFFF0008;
   localparam logic [31:0] A_TCMP   = 32'hFFFF000C;
   localparam logic [31:0] A_TFLAG  = 32'hFFFF0010;

   logic        clk = 1'b0;
   logic        reset, memwrite, tx_ready;
   logic [31:0] addr, writedata, readdata;
   logic [7:0]  tx_data;
   logic        tx_valid, timer_irq;

   always #5 clk = ~clk;

   mem_responder #(.RAM_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .addr      (addr),
      .writedata (writedata),
      .readdata  (readdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .timer_irq (timer_irq)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_rd;

   logic [31:0] m_mem [2**AW];
   bit          m_known [2**AW];
   logic [7:0]  m_q [$];
   bit          m_ovf;
   logic [31:0] m_tcount, m_tcmp;
   bit          m_tflag;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
      logic [4:0] cnt;
      known = 1'b1;
      cnt = 5'(m_q.size());
      if (!a[31]) begin
         known = m_known[a[AW+1:2]];
         return m_mem[a[AW+1:2]];
      end
      if (a[31:16] != 16'hFFFF || a[15:5] != 11'd0) return 32'd0;
      case (a[4:2])
         3'd1:    return {24'd0, cnt, m_ovf, (cnt == 5'd0), (cnt == 5'(DEPTH))};
         3'd2:    return m_tcount;
         3'd3:    return m_tcmp;
         3'd4:    return {31'd0, m_tflag};
         default: return 32'd0;
      endcase
   endfunction

   // One clock: drive, check outputs against the model, advance model and DUT.
   task automatic cycle(input bit rst_n, input bit mw, input logic [31:0] a,
                        input logic [31:0] wd, input bit rdy);
      logic [31:0] exp;
      bit          kn, mmio, pop, full, set;
      logic [2:0]  r;
      reset = rst_n; memwrite = mw; addr = a; writedata = wd; tx_ready = rdy;
      #1;
      exp = model_read(a, kn);
      last_rd = readdata;
      if (kn) check("readdata", readdata, exp);
      check("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) check("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
      check("timer_irq", {31'd0, timer_irq}, {31'd0, m_tflag});
      if (!rst_n) begin
         m_q.delete();
         m_ovf = 0; m_tcount = 0; m_tcmp = 0; m_tflag = 0;
      end else begin
         mmio = (a[31:16] == 16'hFFFF) && (a[15:5] == 11'd0);
         r    = a[4:2];
         pop  = (m_q.size() != 0) && rdy;
         full = (m_q.size() == DEPTH);
         set  = (m_tcmp != 0) && (m_tcount == m_tcmp);
         if (pop) void'(m_q.pop_front());
         if (mw && mmio && r == 3'd0) begin
            if (!full || pop) m_q.push_back(wd[7:0]);
            else m_ovf = 1;
         end else if (mw && mmio && r == 3'd1 && wd[2]) begin
            m_ovf = 0;
         end
         m_tcount = (mw && mmio && r == 3'd2) ? wd : m_tcount + 32'd1;
         if (mw && mmio && r == 3'd3) m_tcmp = wd;
         if (set) m_tflag = 1;
         else if (mw && mmio && r == 3'd4 && wd[0]) m_tflag = 0;
         if (mw && !a[31]) begin
            m_mem[a[AW+1:2]]   = wd;
            m_known[a[AW+1:2]] = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input bit rdy);
      cycle(1'b1, 1'b1, a, wd, rdy);
   endtask

   task automatic rd_const(input string tag, input logic [31:0] a,
                           input logic [31:0] exp, input bit rdy);
      cycle(1'b1, 1'b0, a, 32'd0, rdy);
      check(tag, last_rd, exp);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, wd;
      int          got, sel;
      logic [7:0]  exp_b;

      reset = 1'b0; memwrite = 1'b0; addr = 32'd0; writedata = 32'd0; tx_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      m_q.delete(); m_ovf = 0; m_tcount = 0; m_tcmp = 0; m_tflag = 0;
      cycle(1'b0, 1'b0, A_TXSTAT, 32'd0, 1'b0);

      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_irq", {31'd0, timer_irq}, 32'd0);
      rd_const("rst_tcount", A_TCOUNT, 32'd0, 1'b0);
      rd_const("rst_txstat", A_TXSTAT, 32'h2, 1'b0);
      rd_const("rst_tcmp", A_TCMP, 32'd0, 1'b0);

      for (int i = 0; i < 2**AW; i++) wr(32'(i * 4), $urandom(), 1'b0);

      // RAM aliasing, byte-offset and write-returns-old-value behaviour
      wr(32'h40, 32'hDEADBEEF, 1'b0);
      rd_const("ram_0x40", 32'h40, 32'hDEADBEEF, 1'b0);
      rd_const("ram_alias", 32'h40 + (32'd4 << AW), 32'hDEADBEEF, 1'b0);
      rd_const("ram_0x41", 32'h41, 32'hDEADBEEF, 1'b0);
      wr(32'h40, 32'h12345678, 1'b0);
      check("ram_old_on_write", last_rd, 32'hDEADBEEF);
      rd_const("ram_new", 32'h40, 32'h12345678, 1'b0);
      rd_const("unmapped_mmio", 32'hFFFF0020, 32'd0, 1'b0);
      rd_const("unmapped_hi", 32'h80000000, 32'd0, 1'b0);
      rd_const("txdata_read", A_TXDATA, 32'd0, 1'b0);

      // FIFO fill, overflow and in-order drain
      for (int i = 1; i <= 8; i++) wr(A_TXDATA, 32'(i), 1'b0);
      rd_const("txstat_full", A_TXSTAT, 32'h41, 1'b0);
      wr(A_TXDATA, 32'h9, 1'b0);
      rd_const("txstat_ovf", A_TXSTAT, 32'h45, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         check("drain_byte", {24'd0, tx_data}, 32'(i));
         cycle(1'b1, 1'b0, A_TXSTAT, 32'd0, 1'b1);
      end
      rd_const("txstat_drained", A_TXSTAT, 32'h06, 1'b0);
      wr(A_TXSTAT, 32'h4, 1'b0);
      rd_const("txstat_ovf_clr", A_TXSTAT, 32'h02, 1'b0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'h11 + 32'(i), 1'b0);
      wr(A_TXDATA, 32'hAA, 1'b1);
      rd_const("txstat_pushpop", A_TXSTAT, 32'h41, 1'b0);
      for (int i = 0; i < 8; i++) begin
         exp_b = (i == 7) ? 8'hAA : 8'h12 + 8'(i);
         check("pushpop_byte", {24'd0, tx_data}, {24'd0, exp_b});
         cycle(1'b1, 1'b0, A_TXSTAT, 32'd0, 1'b1);
      end
      rd_const("txstat_empty", A_TXSTAT, 32'h02, 1'b0);

      // Timer compare latency, clear and wrap
      cycle(1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
      wr(A_TCMP, 32'd20, 1'b0);
      wr(A_TCOUNT, 32'd10, 1'b0);
      got = -1;
      for (int k = 1; k <= 40; k++) begin
         cycle(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
         if (timer_irq) begin
            got = k;
            break;
         end
      end
      check("irq_latency", 32'(got), 32'd11);
      wr(A_TFLAG, 32'd1, 1'b0);
      check("irq_cleared", {31'd0, timer_irq}, 32'd0);
      wr(A_TCOUNT, 32'hFFFFFFFE, 1'b0);
      rd_const("tcount_fffe", A_TCOUNT, 32'hFFFFFFFE, 1'b0);
      rd_const("tcount_ffff", A_TCOUNT, 32'hFFFFFFFF, 1'b0);
      rd_const("tcount_wrap", A_TCOUNT, 32'd0, 1'b0);

      // Flag set beats a same-cycle clear
      wr(A_TCMP, 32'd50, 1'b0);
      wr(A_TCOUNT, 32'd47, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, A_TCOUNT, 32'd0, 1'b0);
      rd_const("tcount_at_cmp", A_TCOUNT, 32'd50, 1'b0);
      // that read cycle was the match cycle; redo with a clear write on the match
      wr(A_TFLAG, 32'd1, 1'b0);
      wr(A_TCOUNT, 32'd47, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, A_TCOUNT, 32'd0, 1'b0);
      wr(A_TFLAG, 32'd1, 1'b0);
      check("set_wins", {31'd0, timer_irq}, 32'd1);
      wr(A_TFLAG, 32'd1, 1'b0);
      check("flag_clear", {31'd0, timer_irq}, 32'd0);

      // Reset mid-transfer with queued bytes and the flag set
      for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h30 + 32'(i), 1'b0);
      wr(A_TCMP, 32'd5, 1'b0);
      wr(A_TCOUNT, 32'd5, 1'b0);
      cycle(1'b1, 1'b0, 32'h0, 32'd0, 1'b0);
      check("flag_before_rst", {31'd0, timer_irq}, 32'd1);
      cycle(1'b0, 1'b1, A_TXDATA, 32'h77, 1'b1);
      check("rst2_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst2_irq", {31'd0, timer_irq}, 32'd0);
      rd_const("rst2_tcount", A_TCOUNT, 32'd0, 1'b0);
      rd_const("rst2_txstat", A_TXSTAT, 32'h02, 1'b0);
      rd_const("rst2_ram_kept", 32'h40, 32'h12345678, 1'b0);

      // Random traffic against the model
      for (int k = 0; k < 2000; k++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 3) begin
            a = $urandom() & 32'h7FFFFFFF;
         end else if (sel <= 8) begin
            a = A_TXDATA | ($urandom_range(0, 1) ? 32'd0 : (32'($urandom_range(0, 7)) << 2))
                | 32'($urandom_range(0, 3));
         end else begin
            case ($urandom_range(0, 2))
               0:       a = 32'hFFFF0020 | ($urandom() & 32'h0000FFDF);
               1:       a = 32'h80000000 | ($urandom() & 32'h7FFEFFFF);
               default: a = 32'hFFFE0000 | ($urandom() & 32'h1F);
            endcase
         end
         wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
         cycle(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), a, wd,
               ((k / 200) % 2 == 1) ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
